uart_rx_frame_ctrl: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver. It supports configurable data width, parity, stop bits and oversample ratio, and uses a baud-tick enable instead of treating clk as the tick. Adds a synchroniser, falling-edge start detect, parity/framing/overrun error reporting and a valid/ready output handshake. Sits between the pad-side RX line and the UART register/FIFO layer.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_frame_ctrl.sv | 126 ++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, parity modes and parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (mode == PARITY_ODD) ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop RX synchroniser (idle high) with per-tick falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_Baud_Tick,
  input  logic i_Rx_Data,
  output logic rx_s,
  output logic fall
);
  logic meta, prev_s;
  // synchronise the line every clk; remember the previous tick's sample
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b1;
      rx_s   <= 1'b1;
      prev_s <= 1'b1;
    end else begin
      meta   <= i_Rx_Data;
      rx_s   <= meta;
      if (i_Baud_Tick) prev_s <= rx_s;
    end
  end
  assign fall = prev_s & ~rx_s;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parametrised UART receiver; define UART_RX_MAJORITY_EN for 2-of-3 sampling
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_Baud_Tick,
  input  logic                 i_Rx_Data,
  input  logic                 i_Rx_Ready,
  output logic                 o_Rx_Valid,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun_Err,
  output logic                 o_Busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  state_t state, state_n;
  logic rx_s, fall, nom, fire, smp, perr, ferr, done, accept;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] data;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_Baud_Tick(i_Baud_Tick),
    .i_Rx_Data  (i_Rx_Data),
    .rx_s       (rx_s),
    .fall       (fall)
  );

  assign nom = i_Baud_Tick && (state == START ? tick_cnt == T_HALF :
               (state == DATA || state == PARITY || state == STOP) && tick_cnt == T_FULL);

`ifdef UART_RX_MAJORITY_EN
  logic pend;
  logic [1:0] hist;
  // keep the last two tick samples and resolve the bit one tick after the nominal point
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      hist <= 2'b11;
    end else if (i_Baud_Tick) begin
      pend <= nom;
      hist <= {hist[0], rx_s};
    end
  end
  assign fire = i_Baud_Tick & pend;
  assign smp  = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign fire = nom;
  assign smp  = rx_s;
`endif

  // next-state decode; state changes only when a sample is resolved
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (i_Baud_Tick && fall) ? START : IDLE;
      START:   state_n = fire ? (smp ? IDLE : DATA) : START;
      DATA:    state_n = (fire && bit_cnt == B_LAST) ? (PARITY_MODE != PARITY_NONE ? PARITY : STOP) : DATA;
      PARITY:  state_n = fire ? STOP : PARITY;
      STOP:    state_n = (fire && bit_cnt == S_LAST) ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end

  // state register, bit timing counters and frame assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      data     <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state == STOP && state_n == IDLE;
      if (i_Baud_Tick) tick_cnt <= (state == IDLE || nom) ? '0 : tick_cnt + 1'b1;
      if (fire) bit_cnt <= (state_n != state) ? '0 : bit_cnt + 1'b1;
      if (fire && state == START) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (fire && state == DATA) data <= {smp, data[DATA_BITS-1:1]};
      if (fire && state == PARITY) perr <= smp != parity_bit(9'(data), PARITY_MODE);
      if (fire && state == STOP) ferr <= ferr | ~smp;
    end
  end

  assign accept = o_Rx_Valid & i_Rx_Ready;
  assign o_Busy = state != IDLE;

  // output holding register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      o_Rx_Valid    <= 1'b0;
      o_Rx_Byte     <= '0;
      o_Parity_Err  <= 1'b0;
      o_Frame_Err   <= 1'b0;
      o_Overrun_Err <= 1'b0;
    end else begin
      if (done && (!o_Rx_Valid || accept)) begin
        o_Rx_Byte    <= data;
        o_Parity_Err <= perr;
        o_Frame_Err  <= ferr;
      end
      o_Rx_Valid    <= done | (o_Rx_Valid & ~accept);
      o_Overrun_Err <= ~accept & (o_Overrun_Err | (done & o_Rx_Valid));
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed bench for 8N1 and 7E2 receiver instances
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic [1:0] tdiv = 2'd0;
  logic rx8 = 1'b1, rx7 = 1'b1, rdy8 = 1'b1, rdy7 = 1'b1;
  logic v8, pe8, fe8, ov8, bz8, v7, pe7, fe7, ov7, bz7;
  logic [7:0] b8;
  logic [6:0] b7;
  int checks = 0, failures = 0;
  int vcnt8 = 0, vcnt7 = 0, bcnt8 = 0;
  logic [7:0] cb8 = '0;
  logic [6:0] cb7 = '0;
  logic cpe8 = 0, cfe8 = 0, cpe7 = 0, cfe7 = 0;

  uart_rx_frame_ctrl dut8 (
    .clk(clk), .reset(reset), .i_Baud_Tick(tick), .i_Rx_Data(rx8), .i_Rx_Ready(rdy8),
    .o_Rx_Valid(v8), .o_Rx_Byte(b8), .o_Parity_Err(pe8), .o_Frame_Err(fe8),
    .o_Overrun_Err(ov8), .o_Busy(bz8)
  );

  uart_rx_frame_ctrl #(.OVERSAMPLE(16), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) dut7 (
    .clk(clk), .reset(reset), .i_Baud_Tick(tick), .i_Rx_Data(rx7), .i_Rx_Ready(rdy7),
    .o_Rx_Valid(v7), .o_Rx_Byte(b7), .o_Parity_Err(pe7), .o_Frame_Err(fe7),
    .o_Overrun_Err(ov7), .o_Busy(bz7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tdiv <= tdiv + 2'd1;
    tick <= (tdiv == 2'd3);
  end

  always @(negedge clk) begin
    if (v8) begin
      vcnt8++;
      cb8 = b8; cpe8 = pe8; cfe8 = fe8;
    end
    if (v7) begin
      vcnt7++;
      cb7 = b7; cpe7 = pe7; cfe7 = fe7;
    end
    if (bz8) bcnt8++;
  end

  task automatic drive_bits(input bit sel, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) rx7 = v[i]; else rx8 = v[i];
      repeat (64) @(posedge clk);
      #1;
    end
    if (sel) rx7 = 1'b1; else rx8 = 1'b1;
    repeat (64) @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] b, input logic stop);
    drive_bits(1'b0, {6'h0, stop, b, 1'b0}, 10);
  endtask

  task automatic send7(input logic [6:0] b, input logic p);
    drive_bits(1'b1, {5'h0, 2'b11, p, b, 1'b0}, 11);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (v8 !== 1'b0 || v7 !== 1'b0) begin failures++; $display("FAIL reset_valid got %b/%b want 0/0", v8, v7); end
    checks++; if (b8 !== 8'h00 || b7 !== 7'h00) begin failures++; $display("FAIL reset_byte got %h/%h want 00/00", b8, b7); end
    checks++; if ({pe8, fe8, ov8} !== 3'b000) begin failures++; $display("FAIL reset_err8 got %b want 000", {pe8, fe8, ov8}); end
    checks++; if ({pe7, fe7, ov7} !== 3'b000) begin failures++; $display("FAIL reset_err7 got %b want 000", {pe7, fe7, ov7}); end
    checks++; if (bz8 !== 1'b0 || bz7 !== 1'b0) begin failures++; $display("FAIL reset_busy got %b/%b want 0/0", bz8, bz7); end
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int n0;
    n0 = vcnt8;
    send8(8'hA5, 1'b1);
    checks++; if (vcnt8 - n0 != 1) begin failures++; $display("FAIL basic_pulse got %0d cycles want 1", vcnt8 - n0); end
    checks++; if (cb8 !== 8'hA5) begin failures++; $display("FAIL basic_byte got %h want a5", cb8); end
    checks++; if ({cpe8, cfe8} !== 2'b00) begin failures++; $display("FAIL basic_err got %b want 00", {cpe8, cfe8}); end
    checks++; if (v8 !== 1'b0 || ov8 !== 1'b0 || bz8 !== 1'b0) begin failures++; $display("FAIL basic_after got v=%b ov=%b bz=%b want 000", v8, ov8, bz8); end
  endtask

  task automatic test_parity;
    int n0;
    n0 = vcnt7;
    send7(7'h35, 1'b1);
    checks++; if (vcnt7 - n0 != 1 || cb7 !== 7'h35) begin failures++; $display("FAIL par_bad_byte got %h n=%0d want 35 n=1", cb7, vcnt7 - n0); end
    checks++; if (cpe7 !== 1'b1 || cfe7 !== 1'b0) begin failures++; $display("FAIL par_bad_flags got pe=%b fe=%b want pe=1 fe=0", cpe7, cfe7); end
    send7(7'h35, 1'b0);
    checks++; if (cb7 !== 7'h35) begin failures++; $display("FAIL par_ok_byte got %h want 35", cb7); end
    checks++; if (cpe7 !== 1'b0 || cfe7 !== 1'b0) begin failures++; $display("FAIL par_ok_flags got pe=%b fe=%b want 0 0", cpe7, cfe7); end
  endtask

  task automatic test_frame;
    send8(8'h3C, 1'b0);
    checks++; if (cb8 !== 8'h3C || cfe8 !== 1'b1) begin failures++; $display("FAIL frame_err got %h fe=%b want 3c fe=1", cb8, cfe8); end
    checks++; if (cpe8 !== 1'b0) begin failures++; $display("FAIL frame_pe got %b want 0", cpe8); end
    send8(8'h55, 1'b1);
    checks++; if (cb8 !== 8'h55 || cfe8 !== 1'b0) begin failures++; $display("FAIL frame_next got %h fe=%b want 55 fe=0", cb8, cfe8); end
  endtask

  task automatic test_overrun;
    rdy8 = 1'b0;
    send8(8'h11, 1'b1);
    checks++; if (v8 !== 1'b1 || b8 !== 8'h11 || ov8 !== 1'b0) begin failures++; $display("FAIL ovr_first got v=%b b=%h ov=%b want 1 11 0", v8, b8, ov8); end
    send8(8'h22, 1'b1);
    checks++; if (v8 !== 1'b1 || b8 !== 8'h11) begin failures++; $display("FAIL ovr_hold got v=%b b=%h want 1 11", v8, b8); end
    checks++; if (ov8 !== 1'b1) begin failures++; $display("FAIL ovr_flag got %b want 1", ov8); end
    rdy8 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (v8 !== 1'b0 || ov8 !== 1'b0) begin failures++; $display("FAIL ovr_clear got v=%b ov=%b want 0 0", v8, ov8); end
    checks++; if (b8 !== 8'h11) begin failures++; $display("FAIL ovr_byte_kept got %h want 11", b8); end
  endtask

  task automatic test_glitch;
    int n0, bz0;
    n0 = vcnt8;
    bz0 = bcnt8;
    rx8 = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx8 = 1'b1;
    repeat (128) @(posedge clk);
    #1;
    checks++; if (bcnt8 - bz0 == 0) begin failures++; $display("FAIL glitch_busy got 0 busy cycles want >0"); end
    checks++; if (vcnt8 - n0 != 0 || v8 !== 1'b0) begin failures++; $display("FAIL glitch_valid got %0d pulses want 0", vcnt8 - n0); end
    checks++; if (bz8 !== 1'b0) begin failures++; $display("FAIL glitch_idle got busy=%b want 0", bz8); end
  endtask

  task automatic test_reset_mid;
    int n0;
    rx8 = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    rx8 = 1'b1;
    repeat (224) @(posedge clk);
    #1;
    checks++; if (bz8 !== 1'b1) begin failures++; $display("FAIL mid_busy got %b want 1", bz8); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if ({v8, pe8, fe8, ov8, bz8} !== 5'b0) begin failures++; $display("FAIL mid_flags got %b want 00000", {v8, pe8, fe8, ov8, bz8}); end
    checks++; if (b8 !== 8'h00) begin failures++; $display("FAIL mid_byte got %h want 00", b8); end
    repeat (640) @(posedge clk);
    #1;
    n0 = vcnt8;
    send8(8'h81, 1'b1);
    checks++; if (vcnt8 - n0 != 1 || cb8 !== 8'h81) begin failures++; $display("FAIL mid_next got %h n=%0d want 81 n=1", cb8, vcnt8 - n0); end
    checks++; if ({cpe8, cfe8} !== 2'b00) begin failures++; $display("FAIL mid_next_err got %b want 00", {cpe8, cfe8}); end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority;
    rx8 = 1'b0;
    repeat (64 * 3 + 30) @(posedge clk);
    #1;
    rx8 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx8 = 1'b0;
    repeat (64 * 6 + 30) @(posedge clk);
    #1;
    drive_bits(1'b0, 16'h0001, 1);
    checks++; if (cb8 !== 8'h00 || cfe8 !== 1'b0) begin failures++; $display("FAIL majority got %h fe=%b want 00 fe=0", cb8, cfe8); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_frame;
    test_overrun;
    test_glitch;
    test_reset_mid;
`ifdef UART_RX_MAJORITY_EN
    test_majority;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
